// File: rtl/pix_pkg.sv
// rtl/pix_pkg.sv - shared raster types, request FSM states and default 640x480 timing
package pix_pkg;

  localparam int PIX_CORDW  = 11;
  localparam int PIX_H_RES  = 640;
  localparam int PIX_H_FP   = 16;
  localparam int PIX_H_SYNC = 96;
  localparam int PIX_H_BP   = 48;
  localparam int PIX_V_RES  = 480;
  localparam int PIX_V_FP   = 10;
  localparam int PIX_V_SYNC = 2;
  localparam int PIX_V_BP   = 33;

  typedef struct packed {
    logic [PIX_CORDW-1:0] sx;
    logic [PIX_CORDW-1:0] sy;
    logic                 de;
    logic                 vsync;
    logic                 hsync;
  } pix_sync_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2
  } req_state_t;

endpackage

// File: rtl/line_req_ctrl.sv
// rtl/line_req_ctrl.sv - one-line-ahead render request FSM with saturating underrun counter
module line_req_ctrl
  import pix_pkg::*;
#(
  parameter int CORDW = PIX_CORDW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             due,
  input  logic [CORDW-1:0] nxt,
  input  logic             req_ready,
  input  logic             req_done,
  output logic             req_valid,
  output logic [CORDW-1:0] req_line,
  output logic             underrun,
  output logic [7:0]       underrun_cnt
);

  req_state_t state, state_n;
  logic       load, miss;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (due) state_n = ST_REQ;
      ST_REQ:  if (req_ready) state_n = ST_BUSY;
      ST_BUSY: if (req_done) state_n = due ? ST_REQ : ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // A done landing on the issue cycle frees the slot in time, so it loads instead of missing.
  always_comb begin
    req_valid = (state == ST_REQ);
    load      = 1'b0;
    miss      = 1'b0;
    case (state)
      ST_IDLE: load = due;
      ST_REQ:  miss = due;
      ST_BUSY: begin
        load = due && req_done;
        miss = due && !req_done;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_line     <= '0;
      underrun     <= 1'b0;
      underrun_cnt <= 8'd0;
    end else begin
      if (load) req_line <= nxt;
      underrun <= miss;
      if (miss && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/display_timing.sv
// rtl/display_timing.sv - raster timing generator issuing one-line-ahead render requests
module display_timing
  import pix_pkg::*;
#(
  parameter int CORDW  = PIX_CORDW,
  parameter int H_RES  = PIX_H_RES,
  parameter int H_FP   = PIX_H_FP,
  parameter int H_SYNC = PIX_H_SYNC,
  parameter int H_BP   = PIX_H_BP,
  parameter int V_RES  = PIX_V_RES,
  parameter int V_FP   = PIX_V_FP,
  parameter int V_SYNC = PIX_V_SYNC,
  parameter int V_BP   = PIX_V_BP,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0
) (
  input  logic             clk_pix,
  input  logic             rst_pix_n,
  output logic [CORDW-1:0] o_sx,
  output logic [CORDW-1:0] o_sy,
  output logic             o_de,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_line,
  output logic             o_frame,
  output logic             o_lb_bank,
  output logic             o_req_valid,
  output logic [CORDW-1:0] o_req_line,
  output logic             o_req_bank,
  input  logic             i_req_ready,
  input  logic             i_req_done,
  output logic             o_underrun,
  output logic [7:0]       o_underrun_cnt
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  localparam logic [CORDW-1:0] H_VIS  = CORDW'(H_RES);
  localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] HS_BEG = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0] HS_END = CORDW'(H_RES + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] V_VIS  = CORDW'(V_RES);
  localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] VS_BEG = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] VS_END = CORDW'(V_RES + V_FP + V_SYNC);

  // Parking at the issue column of the last line makes line 0 due on the first cycle out of reset.
  localparam pix_sync_t SYNC_RST = '{
    sx:    PIX_CORDW'(H_RES),
    sy:    PIX_CORDW'(V_TOTAL - 1),
    de:    1'b0,
    vsync: ~VS_POL,
    hsync: ~HS_POL
  };

  pix_sync_t        sync_q, sync_d;
  logic             line_q, frame_q;
  logic [CORDW-1:0] sx, sy, sx_n, sy_n, nxt;
  logic             due;

  assign sx = CORDW'(sync_q.sx);
  assign sy = CORDW'(sync_q.sy);

  // Decode from the next count so every registered flag lines up with o_sx/o_sy.
  always_comb begin
    sx_n = (sx == H_LAST) ? '0 : sx + CORDW'(1);
    sy_n = sy;
    if (sx == H_LAST) sy_n = (sy == V_LAST) ? '0 : sy + CORDW'(1);
    sync_d.sx    = PIX_CORDW'(sx_n);
    sync_d.sy    = PIX_CORDW'(sy_n);
    sync_d.de    = (sx_n < H_VIS) && (sy_n < V_VIS);
    sync_d.hsync = ((sx_n >= HS_BEG) && (sx_n < HS_END)) ? HS_POL : ~HS_POL;
    sync_d.vsync = ((sy_n >= VS_BEG) && (sy_n < VS_END)) ? VS_POL : ~VS_POL;
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      sync_q  <= SYNC_RST;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      line_q  <= (sx_n == '0);
      frame_q <= (sx_n == '0) && (sy_n == '0);
    end
  end

  assign nxt = (sy == V_LAST) ? '0 : sy + CORDW'(1);
  assign due = (sx == H_VIS) && (nxt < V_VIS);

  line_req_ctrl #(
    .CORDW (CORDW)
  ) u_req (
    .clk          (clk_pix),
    .rst_n        (rst_pix_n),
    .due          (due),
    .nxt          (nxt),
    .req_ready    (i_req_ready),
    .req_done     (i_req_done),
    .req_valid    (o_req_valid),
    .req_line     (o_req_line),
    .underrun     (o_underrun),
    .underrun_cnt (o_underrun_cnt)
  );

  assign o_sx       = sx;
  assign o_sy       = sy;
  assign o_de       = sync_q.de;
  assign o_hsync    = sync_q.hsync;
  assign o_vsync    = sync_q.vsync;
  assign o_line     = line_q;
  assign o_frame    = frame_q;
  assign o_lb_bank  = sy[0];
  assign o_req_bank = o_req_line[0];

endmodule

// File: tb/tb_display_timing.sv
// tb/tb_display_timing.sv - directed vector bench for display_timing on a 14x7 raster
module tb_display_timing;

  localparam int CW = 11;

  logic          clk_pix = 1'b0;
  logic          rst_pix_n;
  logic [CW-1:0] o_sx, o_sy, o_req_line;
  logic          o_de, o_hsync, o_vsync, o_line, o_frame, o_lb_bank;
  logic          o_req_valid, o_req_bank, o_underrun;
  logic          i_req_ready, i_req_done;
  logic [7:0]    o_underrun_cnt;

  typedef struct {
    int cyc;
    int sx;
    int sy;
    int de;
    int hs;
    int vs;
    int ln;
    int fr;
    int val;
    int rl;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit auto_done   = 1'b1;
  bit manual_done = 1'b0;

  always #5 clk_pix = ~clk_pix;

  display_timing #(
    .CORDW(CW), .H_RES(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_RES(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk_pix        (clk_pix),
    .rst_pix_n      (rst_pix_n),
    .o_sx           (o_sx),
    .o_sy           (o_sy),
    .o_de           (o_de),
    .o_hsync        (o_hsync),
    .o_vsync        (o_vsync),
    .o_line         (o_line),
    .o_frame        (o_frame),
    .o_lb_bank      (o_lb_bank),
    .o_req_valid    (o_req_valid),
    .o_req_line     (o_req_line),
    .o_req_bank     (o_req_bank),
    .i_req_ready    (i_req_ready),
    .i_req_done     (i_req_done),
    .o_underrun     (o_underrun),
    .o_underrun_cnt (o_underrun_cnt)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk_pix);
    cyc++;
    @(negedge clk_pix);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sx"}, int'(o_sx), 8);
    check({tag, "_sy"}, int'(o_sy), 6);
    check({tag, "_de"}, int'(o_de), 0);
    check({tag, "_hsync"}, int'(o_hsync), 1);
    check({tag, "_vsync"}, int'(o_vsync), 1);
    check({tag, "_line"}, int'(o_line), 0);
    check({tag, "_frame"}, int'(o_frame), 0);
    check({tag, "_req_valid"}, int'(o_req_valid), 0);
    check({tag, "_req_line"}, int'(o_req_line), 0);
    check({tag, "_underrun"}, int'(o_underrun), 0);
    check({tag, "_underrun_cnt"}, int'(o_underrun_cnt), 0);
  endtask

  // Renderer model: done pulses 3 cycles after each accepted request while auto_done is set.
  initial begin
    int cd;
    cd = 0;
    i_req_done = 1'b0;
    forever begin
      @(negedge clk_pix);
      #2;
      i_req_done = manual_done;
      if (cd > 0) begin
        cd--;
        if (cd == 0 && auto_done) i_req_done = 1'b1;
      end
      if (!rst_pix_n) cd = 0;
      else if (auto_done && o_req_valid && i_req_ready) cd = 3;
    end
  end

  initial begin
    vec_t vecs[20];
    int   vi, lin, model_err, de_n, hs_n, vs_n, fr_n, ln_n, urun_n, urun_at;
    int   hold_err, pulses, pos_err, cnt_err, guard, more, exp_cnt;

    vecs[0]  = '{0,   8, 6, 0, 1, 1, 0, 0, 0, 0};
    vecs[1]  = '{1,   9, 6, 0, 1, 1, 0, 0, 1, 0};
    vecs[2]  = '{2,  10, 6, 0, 0, 1, 0, 0, 0, 0};
    vecs[3]  = '{3,  11, 6, 0, 0, 1, 0, 0, 0, 0};
    vecs[4]  = '{4,  12, 6, 0, 1, 1, 0, 0, 0, 0};
    vecs[5]  = '{6,   0, 0, 1, 1, 1, 1, 1, 0, 0};
    vecs[6]  = '{7,   1, 0, 1, 1, 1, 0, 0, 0, 0};
    vecs[7]  = '{13,  7, 0, 1, 1, 1, 0, 0, 0, 0};
    vecs[8]  = '{14,  8, 0, 0, 1, 1, 0, 0, 0, 0};
    vecs[9]  = '{15,  9, 0, 0, 1, 1, 0, 0, 1, 1};
    vecs[10] = '{16, 10, 0, 0, 0, 1, 0, 0, 0, 1};
    vecs[11] = '{20,  0, 1, 1, 1, 1, 1, 0, 0, 1};
    vecs[12] = '{29,  9, 1, 0, 1, 1, 0, 0, 1, 2};
    vecs[13] = '{43,  9, 2, 0, 1, 1, 0, 0, 1, 3};
    vecs[14] = '{57,  9, 3, 0, 1, 1, 0, 0, 0, 3};
    vecs[15] = '{71,  9, 4, 0, 1, 1, 0, 0, 0, 3};
    vecs[16] = '{76,  0, 5, 0, 1, 0, 1, 0, 0, 3};
    vecs[17] = '{85,  9, 5, 0, 1, 0, 0, 0, 0, 3};
    vecs[18] = '{99,  9, 6, 0, 1, 1, 0, 0, 1, 0};
    vecs[19] = '{104, 0, 0, 1, 1, 1, 1, 1, 0, 0};

    rst_pix_n   = 1'b0;
    i_req_ready = 1'b1;
    repeat (3) @(posedge clk_pix);
    @(negedge clk_pix);
    check_reset_values("por");
    rst_pix_n = 1'b1;
    cyc = 0;

    vi = 0; model_err = 0; de_n = 0; hs_n = 0; vs_n = 0; fr_n = 0; ln_n = 0; urun_n = 0;
    for (int c = 0; c <= 104; c++) begin
      if (c > 0) step();
      lin = (92 + c) % 98;
      if (int'(o_sx) != lin % 14 || int'(o_sy) != lin / 14) model_err++;
      if (c >= 6 && c <= 103) begin
        de_n += int'(o_de);
        hs_n += int'(!o_hsync);
        vs_n += int'(!o_vsync);
        fr_n += int'(o_frame);
        ln_n += int'(o_line);
      end
      urun_n += int'(o_underrun);
      if (vi < 20 && vecs[vi].cyc == c) begin
        check("vec_sx", int'(o_sx), vecs[vi].sx);
        check("vec_sy", int'(o_sy), vecs[vi].sy);
        check("vec_de", int'(o_de), vecs[vi].de);
        check("vec_hsync", int'(o_hsync), vecs[vi].hs);
        check("vec_vsync", int'(o_vsync), vecs[vi].vs);
        check("vec_line", int'(o_line), vecs[vi].ln);
        check("vec_frame", int'(o_frame), vecs[vi].fr);
        check("vec_lb_bank", int'(o_lb_bank), vecs[vi].sy % 2);
        check("vec_req_valid", int'(o_req_valid), vecs[vi].val);
        check("vec_req_line", int'(o_req_line), vecs[vi].rl);
        check("vec_req_bank", int'(o_req_bank), vecs[vi].rl % 2);
        vi++;
      end
    end
    check("vectors_applied", vi, 20);
    check("counter_model_err", model_err, 0);
    check("frame_de_cycles", de_n, 32);
    check("frame_hsync_cycles", hs_n, 14);
    check("frame_vsync_cycles", vs_n, 14);
    check("frame_pulses", fr_n, 1);
    check("line_pulses", ln_n, 7);
    check("no_underrun_normal", urun_n, 0);

    // Stall: line 2 request held across the line 3 issue point.
    while (cyc < 126) step();
    i_req_ready = 1'b0;
    hold_err = 0; urun_n = 0; urun_at = -1;
    while (cyc < 166) begin
      step();
      if (cyc >= 127 && (!o_req_valid || int'(o_req_line) != 2)) hold_err++;
      if (o_underrun) begin
        urun_n++;
        urun_at = cyc;
      end
    end
    i_req_ready = 1'b1;
    check("stall_hold_err", hold_err, 0);
    check("stall_underrun_pulses", urun_n, 1);
    check("stall_underrun_cycle", urun_at, 141);
    check("stall_underrun_cnt", int'(o_underrun_cnt), 1);
    step();
    check("stall_released_valid", int'(o_req_valid), 0);

    while (cyc < 180) step();
    auto_done = 1'b0;

    // Done on the issue cycle while busy.
    while (cyc < 197) step();
    check("line0_valid", int'(o_req_valid), 1);
    check("line0_line", int'(o_req_line), 0);
    while (cyc < 210) step();
    check("busy_before_done", int'(o_req_valid), 0);
    manual_done = 1'b1;
    step();
    manual_done = 1'b0;
    check("coinc_valid", int'(o_req_valid), 1);
    check("coinc_line", int'(o_req_line), 1);
    check("coinc_underrun", int'(o_underrun), 0);
    check("coinc_cnt", int'(o_underrun_cnt), 1);

    // No more done pulses: every due issue point is an underrun until the count saturates.
    pulses = 0; pos_err = 0; cnt_err = 0; guard = 0;
    while (pulses < 254 && guard < 40000) begin
      step();
      guard++;
      if (o_underrun) begin
        pulses++;
        if (int'(o_sx) != 9) pos_err++;
        exp_cnt = (1 + pulses > 255) ? 255 : 1 + pulses;
        if (int'(o_underrun_cnt) != exp_cnt) cnt_err++;
      end
    end
    check("sat_pulses", pulses, 254);
    check("sat_cnt", int'(o_underrun_cnt), 255);
    check("sat_pulse_position_err", pos_err, 0);
    check("sat_cnt_track_err", cnt_err, 0);
    more = 0;
    repeat (196) begin
      step();
      more += int'(o_underrun);
    end
    check("post_sat_pulses", more, 8);
    check("post_sat_cnt", int'(o_underrun_cnt), 255);

    // Asynchronous reset while a request is pending.
    i_req_ready = 1'b0;
    manual_done = 1'b1;
    step();
    manual_done = 1'b0;
    guard = 0;
    while (!o_req_valid && guard < 200) begin
      step();
      guard++;
    end
    check("pre_reset_req_valid", int'(o_req_valid), 1);
    step();
    #3;
    rst_pix_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    @(negedge clk_pix);
    rst_pix_n   = 1'b1;
    i_req_ready = 1'b1;
    cyc = 0;
    check("restart_c0_valid", int'(o_req_valid), 0);
    step();
    check("restart_c1_valid", int'(o_req_valid), 1);
    check("restart_c1_line", int'(o_req_line), 0);
    check("restart_c1_bank", int'(o_req_bank), 0);
    check("restart_c1_sx", int'(o_sx), 9);
    check("restart_c1_sy", int'(o_sy), 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_timing.md
Name: display_timing

Overview:
Upstream pixel-clock stage that generates raster timing (sx, sy, de, hsync, vsync) for the pix pipeline and linebuffer read side.
Issues one render request per visible line to the line renderer over a valid/ready handshake, one line ahead, into the linebuffer bank not being displayed.
Detects and counts render underruns.
Sits between the line renderer/linebuffer and the pix pipeline, in the clk_pix domain only.

Parameters:
CORDW, 11, coordinate width
H_RES, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync width
H_BP, 48, horizontal back porch
V_RES, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync width
V_BP, 33, vertical back porch
HS_POL, 0, hsync active level
VS_POL, 0, vsync active level

Ports:
clk_pix  in  1  pixel clock
rst_pix_n  in  1  asynchronous active-low reset
o_sx  out  CORDW  horizontal counter
o_sy  out  CORDW  vertical counter
o_de  out  1  visible-area enable
o_hsync  out  1  horizontal sync at HS_POL
o_vsync  out  1  vertical sync at VS_POL
o_line  out  1  one-cycle pulse when sx==0
o_frame  out  1  one-cycle pulse when sx==0 && sy==0
o_lb_bank  out  1  linebuffer bank being read, = sy[0]
o_req_valid  out  1  render request valid
o_req_line  out  CORDW  line to render
o_req_bank  out  1  target bank, = o_req_line[0]
i_req_ready  in  1  renderer accepts request
i_req_done  in  1  one-cycle pulse when the accepted line is fully written
o_underrun  out  1  one-cycle pulse on a missed deadline
o_underrun_cnt  out  8  saturating underrun count

Behaviour:
- Clock and reset: single clock clk_pix; reset rst_pix_n is asynchronous and active-low.
- Totals: H_TOTAL = sum of the H params; V_TOTAL = sum of the V params.
- Counters:
  - sx increments every cycle and wraps H_TOTAL-1 -> 0.
  - sy increments on the sx wrap and wraps V_TOTAL-1 -> 0.
  - All timing outputs are registered and coherent with o_sx/o_sy in the same cycle.
- Timing decode:
  - de = sx<H_RES && sy<V_RES.
  - hsync active when H_RES+H_FP <= sx < H_RES+H_FP+H_SYNC.
  - vsync active when V_RES+V_FP <= sy < V_RES+V_FP+V_SYNC.
- Reset values:
  - sx=H_RES, sy=V_TOTAL-1; de=0; hsync=!HS_POL; vsync=!VS_POL.
  - o_line=0, o_frame=0, o_req_valid=0, o_req_line=0, o_underrun=0, o_underrun_cnt=0, request FSM=IDLE.
- Issue point:
  - Occurs on the cycle where sx==H_RES.
  - nxt = (sy==V_TOTAL-1) ? 0 : sy+1.
  - A request is due only if nxt<V_RES. Line 0 is due on the last blank line.
  - The first issue point after reset release is therefore the first cycle.
- Request FSM (IDLE, REQ, BUSY):
  - IDLE: if due, load o_req_line=nxt, assert o_req_valid next cycle, go REQ.
  - REQ: o_req_valid and o_req_line held stable until i_req_ready. On the valid&&ready cycle, deassert next cycle and go BUSY.
  - BUSY: i_req_done -> IDLE. i_req_done in IDLE/REQ is ignored.
- Underrun:
  - Triggered when an issue point is due while the FSM is in REQ or BUSY.
  - o_underrun pulses one cycle; o_underrun_cnt increments and saturates at 255.
  - The new request is skipped; the outstanding request is never withdrawn.
- Simultaneous done and issue: if i_req_done arrives on the issue cycle in BUSY, it counts as complete. No underrun; the new request loads and the FSM goes to REQ.
- Simultaneous ready and issue: if i_req_ready arrives on the issue cycle in REQ, it is still an underrun (the line was not rendered). The handshake completes normally and the FSM goes to BUSY.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); any pending request is dropped.
- Downstream contract: o_lb_bank/o_sx drive the linebuffer read address. Their one-cycle read latency is absorbed by downstream registering.

Decomposition:
- Shared package pix_pkg:
  - pix_sync_t struct (sx, sy, de, vsync, hsync).
  - Request FSM state enum.
  - Default 640x480 timing localparams.
- One sub-module, line_req_ctrl: request FSM plus underrun counter. Inputs are the issue/due strobe and nxt. The timing counters stay in display_timing.

Test Plan:
- Small timing (H_RES=8, H_FP=2, H_SYNC=2, H_BP=2; V_RES=4, V_FP=1, V_SYNC=1, V_BP=1), i_req_ready=1, done 3 cycles after accept:
  - hsync active at sx 10-11, vsync active at sy 5.
  - de high for 32 cycles per 98-cycle frame.
  - o_frame pulses every 98 cycles.
- Reset release:
  - Cycle 1: o_req_valid=1, o_req_line=0, o_req_bank=0.
  - Then lines 1, 2, 3 requested at sx==8 of sy 0, 1, 2.
  - No request at sy 3-5.
- Stall: i_req_ready=0 for 40 cycles:
  - o_req_valid and o_req_line stay stable.
  - o_underrun pulses at the next sx==8.
  - o_underrun_cnt=1.
- Never assert i_req_done: one underrun per due issue point; o_underrun_cnt saturates at 255 after 255 events.
- i_req_done coincident with issue cycle: no underrun, new request issued.
- Assert rst_pix_n low mid-REQ: outputs reach reset values without a clock edge; sequence restarts with line 0.
